// File: rtl/sram_fifo_outstage.sv
// rtl/sram_fifo_outstage.sv - two-slot output stage (SRAM read register + skid) with pop steering
module sram_fifo_outstage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ren,
  input  logic [WIDTH-1:0] sram_rdata,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             rd_valid,
  output logic             skid_valid,
  output logic             pop
);

  logic [WIDTH-1:0] skid;
  logic             pop_rd;
  logic             skid_keep;
  logic             skid_load;

  // Head selection and slot steering: skid always holds the older entry.
  always_comb begin
    out_valid = skid_valid | rd_valid;
    out_data  = skid_valid ? skid : sram_rdata;
    pop       = out_valid & out_ready;
    pop_rd    = pop & ~skid_valid;
    skid_keep = skid_valid & ~pop;
    // A new read is landing on top of an unconsumed rd entry, so park it in skid.
    skid_load = ~skid_keep & ren & rd_valid & ~pop_rd;
  end

  // Slot occupancy and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      skid_valid <= 1'b0;
      skid       <= '0;
    end else begin
      rd_valid   <= ren | (rd_valid & ~pop_rd);
      skid_valid <= skid_keep | skid_load;
      if (skid_load) begin
        skid <= sram_rdata;
      end
    end
  end

endmodule

// File: rtl/sram_fifo_prefetch.sv
// rtl/sram_fifo_prefetch.sv - SRAM-backed valid/ready FIFO with read prefetch; SRAM_FIFO_LEVEL_EN adds level port
module sram_fifo_prefetch #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int W_ADDR = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SRAM_FIFO_LEVEL_EN
  ,
  output logic [W_ADDR+1:0] level
`endif
);

  localparam logic [W_ADDR:0] FULL_COUNT = (W_ADDR+1)'(DEPTH);

  logic [W_ADDR:0]  wptr;
  logic [W_ADDR:0]  rptr;
  logic [W_ADDR:0]  mem_count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sram_rdata;
  logic             push;
  logic             pop;
  logic             ren;
  logic             rd_valid;
  logic             skid_valid;

  // Occupancy, push acceptance and read issue, all from registered pointers.
  always_comb begin
    mem_count = wptr - rptr;
    in_ready  = (mem_count != FULL_COUNT);
    push      = in_valid & in_ready;
    // Issue only while an output slot will be free after this cycle's pop.
    ren       = (mem_count != '0) & (~(rd_valid & skid_valid) | pop);
  end

  // Write and read pointers, wrapping mod 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (ren) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // 1R1W synchronous memory with a ren-gated registered read port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[W_ADDR-1:0]] <= in_data;
    end
    if (ren) begin
      sram_rdata <= mem[rptr[W_ADDR-1:0]];
    end
  end

  sram_fifo_outstage #(
    .WIDTH(WIDTH)
  ) u_outstage (
    .clk        (clk),
    .rst_n      (rst_n),
    .ren        (ren),
    .sram_rdata (sram_rdata),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .rd_valid   (rd_valid),
    .skid_valid (skid_valid),
    .pop        (pop)
  );

`ifdef SRAM_FIFO_LEVEL_EN
  // Total occupancy: a read issue only moves an entry, so only push and pop change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`endif

endmodule
